ray_bounce_ctrl: RTL and testbench

// - Per-pixel path controller directly downstream of the ray intersector; drives its ray inputs.
// - Accepts one camera ray and issues it, then consumes each closest-hit result.
// - On a hit: accumulates emitted light, attenuates throughput, and issues the reflected ray.
// - Terminates on miss, bounce limit or zero throughput, then presents one RGB888 pixel colour.

---
 rtl/ray_bounce_ctrl_pkg.sv | 96 +++++++++
 rtl/ray_bounce_ctrl_reflect_unit.sv | 62 ++++++
 rtl/ray_bounce_ctrl.sv | 143 ++++++++++++++
 tb/tb_ray_bounce_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_bounce_ctrl_pkg.sv
// ray_bounce_ctrl_pkg: shared types, FSM encoding and colour/vector arithmetic
// for the per-pixel bounce controller (fixed point Q8.8, RGB888 colours).
`timescale 1ns/1ps
`default_nettype none

package ray_bounce_ctrl_pkg;

  localparam int FP_W            = 16;
  localparam int FP_FRAC         = 8;
  localparam int MAX_BOUNCES_DEF = 4;

  typedef logic signed [FP_W-1:0] fp_t;

  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } fp_vec3;

  typedef struct packed {
    logic [23:0] color;
    logic [23:0] emit;
  } material;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_HIT = 3'd2,
    S_REFLECT  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Rounded 8x8 channel product; 255*255 maps to 254, so throughput always decays.
  function automatic logic [7:0] ch_mul(logic [7:0] a, logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b) + 16'd128;
    return p[15:8];
  endfunction

  function automatic logic [23:0] rgb_mul(logic [23:0] a, logic [23:0] b);
    logic [23:0] r;
    for (int i = 0; i < 3; i++) r[8*i +: 8] = ch_mul(a[8*i +: 8], b[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [23:0] rgb_add_sat(logic [23:0] a, logic [23:0] b);
    logic [23:0] r;
    logic [8:0]  s;
    for (int i = 0; i < 3; i++) begin
      s = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]};
      r[8*i +: 8] = s[8] ? 8'hFF : s[7:0];
    end
    return r;
  endfunction

  function automatic fp_t fp_mul(fp_t a, fp_t b);
    logic signed [2*FP_W-1:0] p;
    p = (2*FP_W)'(a) * (2*FP_W)'(b);
    return p[FP_FRAC +: FP_W];
  endfunction

  function automatic fp_t vec_dot(fp_vec3 a, fp_vec3 b);
    logic signed [2*FP_W+1:0] s;
    s = (2*FP_W+2)'(a.x) * (2*FP_W+2)'(b.x)
      + (2*FP_W+2)'(a.y) * (2*FP_W+2)'(b.y)
      + (2*FP_W+2)'(a.z) * (2*FP_W+2)'(b.z);
    return s[FP_FRAC +: FP_W];
  endfunction

  function automatic fp_vec3 vec_scale(fp_vec3 v, fp_t s);
    fp_vec3 r;
    r.x = fp_mul(v.x, s);
    r.y = fp_mul(v.y, s);
    r.z = fp_mul(v.z, s);
    return r;
  endfunction

  function automatic fp_vec3 vec_add(fp_vec3 a, fp_vec3 b);
    fp_vec3 r;
    r.x = a.x + b.x;
    r.y = a.y + b.y;
    r.z = a.z + b.z;
    return r;
  endfunction

  function automatic fp_vec3 vec_sub(fp_vec3 a, fp_vec3 b);
    fp_vec3 r;
    r.x = a.x - b.x;
    r.y = a.y - b.y;
    r.z = a.z - b.z;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ray_bounce_ctrl_reflect_unit.sv
// reflect_unit: mirror reflection of a ray about a surface normal, with the new
// origin nudged one LSB along the normal; fixed REFLECT_DELAY-cycle pipeline.
`timescale 1ns/1ps
`default_nettype none

module reflect_unit
  import ray_bounce_ctrl_pkg::*;
#(
  parameter int REFLECT_DELAY = 6
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  input  fp_vec3 dir,
  input  fp_vec3 normal,
  input  fp_vec3 pos,
  output logic   out_valid,
  output fp_vec3 new_dir,
  output fp_vec3 new_origin
);

  localparam fp_t c_nudge = fp_t'(1);

  fp_t    w_dot2;
  fp_vec3 w_dir;
  fp_vec3 w_org;

  logic   [REFLECT_DELAY-1:0] r_vld;
  fp_vec3 [REFLECT_DELAY-1:0] r_dir;
  fp_vec3 [REFLECT_DELAY-1:0] r_org;

  always_comb begin
    w_dot2 = vec_dot(dir, normal) <<< 1;
    w_dir  = vec_sub(dir, vec_scale(normal, w_dot2));
    // n * 2^-8 in Q8.8 is the normal scaled by one LSB
    w_org  = vec_add(pos, vec_scale(normal, c_nudge));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_dir <= '0;
      r_org <= '0;
    end else begin
      r_vld[0] <= in_valid;
      r_dir[0] <= w_dir;
      r_org[0] <= w_org;
      for (int s = 1; s < REFLECT_DELAY; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_dir[s] <= r_dir[s-1];
        r_org[s] <= r_org[s-1];
      end
    end
  end

  assign out_valid  = r_vld[REFLECT_DELAY-1];
  assign new_dir    = r_dir[REFLECT_DELAY-1];
  assign new_origin = r_org[REFLECT_DELAY-1];

endmodule

`default_nettype wire

// File: rtl/ray_bounce_ctrl.sv
// ray_bounce_ctrl: per-pixel path controller feeding the ray intersector; bounces
// the ray, accumulates light/throughput and emits one RGB888 pixel.
`timescale 1ns/1ps
`default_nettype none

module ray_bounce_ctrl
  import ray_bounce_ctrl_pkg::*;
#(
  parameter int          MAX_BOUNCES   = MAX_BOUNCES_DEF,
  parameter int          REFLECT_DELAY = 6,
  parameter logic [23:0] SKY_COLOR     = 24'h6080C0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cam_valid,
  output logic        cam_ready,
  input  fp_vec3      cam_origin,
  input  fp_vec3      cam_dir,
  output fp_vec3      ray_origin,
  output fp_vec3      ray_dir,
  output logic        ray_valid,
  input  logic        hit_valid,
  input  logic        hit_any,
  input  material     hit_mat,
  input  fp_vec3      hit_pos,
  input  fp_vec3      hit_normal,
  output logic [23:0] pix_color,
  output logic        pix_valid,
  output logic        busy
);

  localparam int c_bounce_w = $clog2(MAX_BOUNCES + 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [c_bounce_w-1:0]   r_bounce;
  logic [23:0]             r_thr;
  logic [23:0]             r_acc;
  logic [23:0]             w_thr_upd;
  logic [23:0]             w_acc_upd;
  logic                    w_refl_start;
  logic                    w_refl_valid;
  fp_vec3                  w_refl_dir;
  fp_vec3                  w_refl_org;

  reflect_unit #(
    .REFLECT_DELAY (REFLECT_DELAY)
  ) u_reflect (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (w_refl_start),
    .dir        (ray_dir),
    .normal     (hit_normal),
    .pos        (hit_pos),
    .out_valid  (w_refl_valid),
    .new_dir    (w_refl_dir),
    .new_origin (w_refl_org)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_acc_upd    = r_acc;
    w_thr_upd    = r_thr;
    w_refl_start = 1'b0;
    case (r_state)
      S_IDLE:  if (cam_valid) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT_HIT;
      S_WAIT_HIT: begin
        if (hit_valid) begin
          if (!hit_any) begin
            w_acc_upd = rgb_add_sat(r_acc, rgb_mul(r_thr, SKY_COLOR));
            w_next    = S_DONE;
          end else begin
            w_acc_upd = rgb_add_sat(r_acc, rgb_mul(r_thr, hit_mat.emit));
            w_thr_upd = rgb_mul(r_thr, hit_mat.color);
            // r_bounce already counts the ray whose result is arriving now
            if (r_bounce == c_bounce_w'(MAX_BOUNCES) || w_thr_upd == 24'd0) begin
              w_next = S_DONE;
            end else begin
              w_next       = S_REFLECT;
              w_refl_start = 1'b1;
            end
          end
        end
      end
      S_REFLECT: if (w_refl_valid) w_next = S_ISSUE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ray_origin <= '0;
      ray_dir    <= '0;
      r_thr      <= '0;
      r_acc      <= '0;
      r_bounce   <= '0;
      pix_color  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cam_valid) begin
            ray_origin <= cam_origin;
            ray_dir    <= cam_dir;
            r_thr      <= 24'hFFFFFF;
            r_acc      <= 24'd0;
            r_bounce   <= '0;
          end
        end
        S_ISSUE: r_bounce <= r_bounce + c_bounce_w'(1);
        S_WAIT_HIT: begin
          if (hit_valid) begin
            r_acc <= w_acc_upd;
            r_thr <= w_thr_upd;
            // load on entry so the colour lines up with the DONE strobe
            if (w_next == S_DONE) pix_color <= w_acc_upd;
          end
        end
        S_REFLECT: begin
          if (w_refl_valid) begin
            ray_origin <= w_refl_org;
            ray_dir    <= w_refl_dir;
          end
        end
        default: ;
      endcase
    end
  end

  assign cam_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign ray_valid = (r_state == S_ISSUE);
  assign pix_valid = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_ray_bounce_ctrl.sv
// tb_ray_bounce_ctrl: directed + randomised checks of ray_bounce_ctrl against a
// per-pixel path model (integer colour maths, longint reflection).
`timescale 1ns/1ps
`default_nettype none

module tb_ray_bounce_ctrl;
  import ray_bounce_ctrl_pkg::*;

  localparam int          MAX_B = 4;
  localparam int          RDLY  = 6;
  localparam logic [23:0] SKY   = 24'h6080C0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cam_valid = 1'b0;
  logic        cam_ready;
  fp_vec3      cam_origin = '0;
  fp_vec3      cam_dir = '0;
  fp_vec3      ray_origin;
  fp_vec3      ray_dir;
  logic        ray_valid;
  logic        hit_valid = 1'b0;
  logic        hit_any = 1'b0;
  material     hit_mat = '0;
  fp_vec3      hit_pos = '0;
  fp_vec3      hit_normal = '0;
  logic [23:0] pix_color;
  logic        pix_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int ray_cnt = 0;
  int pix_cnt = 0;
  logic [23:0] last_pix = 24'd0;

  logic    resp_hit [8];
  material resp_mat [8];
  fp_vec3  resp_pos [8];
  fp_vec3  resp_n   [8];

  ray_bounce_ctrl #(
    .MAX_BOUNCES   (MAX_B),
    .REFLECT_DELAY (RDLY),
    .SKY_COLOR     (SKY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cam_valid  (cam_valid),
    .cam_ready  (cam_ready),
    .cam_origin (cam_origin),
    .cam_dir    (cam_dir),
    .ray_origin (ray_origin),
    .ray_dir    (ray_dir),
    .ray_valid  (ray_valid),
    .hit_valid  (hit_valid),
    .hit_any    (hit_any),
    .hit_mat    (hit_mat),
    .hit_pos    (hit_pos),
    .hit_normal (hit_normal),
    .pix_color  (pix_color),
    .pix_valid  (pix_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ray_valid) ray_cnt++;
    if (pix_valid) pix_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Colour model: each channel is a fraction of 256, rounded to nearest.
  function automatic logic [23:0] m_mul(logic [23:0] a, logic [23:0] b);
    logic [23:0] r;
    int ca, cb;
    r = 24'd0;
    for (int i = 0; i < 3; i++) begin
      ca = int'((a >> (8*i)) & 24'hFF);
      cb = int'((b >> (8*i)) & 24'hFF);
      r  = r | (24'((ca * cb + 128) / 256) << (8*i));
    end
    return r;
  endfunction

  function automatic logic [23:0] m_add(logic [23:0] a, logic [23:0] b);
    logic [23:0] r;
    int s;
    r = 24'd0;
    for (int i = 0; i < 3; i++) begin
      s = int'((a >> (8*i)) & 24'hFF) + int'((b >> (8*i)) & 24'hFF);
      if (s > 255) s = 255;
      r = r | (24'(s) << (8*i));
    end
    return r;
  endfunction

  function automatic longint w16(longint v);
    return longint'(shortint'(v));
  endfunction

  function automatic fp_vec3 m_refl_dir(fp_vec3 d, fp_vec3 n);
    longint dot, d2;
    fp_vec3 r;
    dot = w16((longint'(d.x) * n.x + longint'(d.y) * n.y + longint'(d.z) * n.z) >>> 8);
    d2  = w16(dot * 2);
    r.x = fp_t'(d.x - w16((longint'(n.x) * d2) >>> 8));
    r.y = fp_t'(d.y - w16((longint'(n.y) * d2) >>> 8));
    r.z = fp_t'(d.z - w16((longint'(n.z) * d2) >>> 8));
    return r;
  endfunction

  function automatic fp_vec3 m_refl_org(fp_vec3 p, fp_vec3 n);
    fp_vec3 r;
    r.x = fp_t'(p.x + (longint'(n.x) >>> 8));
    r.y = fp_t'(p.y + (longint'(n.y) >>> 8));
    r.z = fp_t'(p.z + (longint'(n.z) >>> 8));
    return r;
  endfunction

  function automatic fp_vec3 rnd_vec(int span);
    fp_vec3 v;
    v.x = fp_t'(int'($urandom_range(0, 2*span)) - span);
    v.y = fp_t'(int'($urandom_range(0, 2*span)) - span);
    v.z = fp_t'(int'($urandom_range(0, 2*span)) - span);
    return v;
  endfunction

  function automatic fp_vec3 rnd_normal();
    fp_vec3 v;
    fp_t    s;
    v = '0;
    s = ($urandom_range(0, 1) != 0) ? fp_t'(256) : fp_t'(-256);
    case ($urandom_range(0, 2))
      0:       v.x = s;
      1:       v.y = s;
      default: v.z = s;
    endcase
    return v;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < 8; i++) begin
      resp_hit[i]       = ($urandom_range(0, 4) != 0);
      resp_mat[i].color = ($urandom_range(0, 5) == 0) ? 24'd0 : (24'($urandom) | 24'h808080);
      resp_mat[i].emit  = 24'($urandom) & 24'h7F7F7F;
      resp_pos[i]       = rnd_vec(2000);
      resp_n[i]         = rnd_normal();
    end
  endtask

  task automatic do_pixel(input fp_vec3 o, input fp_vec3 d, input int lat,
                          input bit hold_cam, input string name);
    logic [23:0] thr, acc;
    fp_vec3      cd, co;
    int          rays0, pix0, nrays, to;
    bit          done;
    @(negedge clk);
    chk({name, ":cam_ready"}, 64'(cam_ready), 64'd1);
    cam_origin = o;
    cam_dir    = d;
    cam_valid  = 1'b1;
    @(negedge clk);
    cam_valid = 1'b0;
    rays0 = ray_cnt;
    pix0  = pix_cnt;
    thr = 24'hFFFFFF; acc = 24'd0; cd = d; co = o; nrays = 0; done = 1'b0;
    for (int b = 0; b < MAX_B && !done; b++) begin
      to = 0;
      while (ray_valid !== 1'b1 && to < 40) begin
        @(negedge clk);
        to++;
      end
      chk({name, ":ray_issue"}, 64'(ray_valid), 64'd1);
      if (ray_valid !== 1'b1) return;
      chk({name, ":ray_dir"}, 64'(ray_dir), 64'(cd));
      chk({name, ":ray_origin"}, 64'(ray_origin), 64'(co));
      nrays++;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        if (hold_cam) begin
          cam_valid = 1'b1;
          cam_dir   = rnd_vec(256);
          chk({name, ":cam_ready_busy"}, 64'(cam_ready), 64'd0);
        end
      end
      cam_valid  = 1'b0;
      hit_valid  = 1'b1;
      hit_any    = resp_hit[b];
      hit_mat    = resp_mat[b];
      hit_pos    = resp_pos[b];
      hit_normal = resp_n[b];
      @(negedge clk);
      hit_valid  = 1'b0;
      hit_mat    = material'({$urandom, $urandom});
      hit_pos    = rnd_vec(3000);
      hit_normal = rnd_vec(3000);
      if (!resp_hit[b]) begin
        acc  = m_add(acc, m_mul(thr, SKY));
        done = 1'b1;
      end else begin
        acc = m_add(acc, m_mul(thr, resp_mat[b].emit));
        thr = m_mul(thr, resp_mat[b].color);
        if (b + 1 == MAX_B || thr == 24'd0) done = 1'b1;
        else begin
          cd = m_refl_dir(cd, resp_n[b]);
          co = m_refl_org(resp_pos[b], resp_n[b]);
        end
      end
      if (done) begin
        chk({name, ":pix_valid"}, 64'(pix_valid), 64'd1);
        chk({name, ":pix_color"}, 64'(pix_color), 64'(acc));
      end
    end
    @(negedge clk);
    chk({name, ":pix_pulse_end"}, 64'(pix_valid), 64'd0);
    chk({name, ":pix_hold"}, 64'(pix_color), 64'(acc));
    chk({name, ":idle"}, 64'(busy), 64'd0);
    chk({name, ":ray_count"}, 64'(ray_cnt - rays0), 64'(nrays));
    chk({name, ":pix_count"}, 64'(pix_cnt - pix0), 64'd1);
    last_pix = acc;
  endtask

  initial begin
    fp_vec3 z3;
    int     pix0, to;
    z3 = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst:ray_valid", 64'(ray_valid), 64'd0);
    chk("rst:pix_valid", 64'(pix_valid), 64'd0);
    chk("rst:pix_color", 64'(pix_color), 64'd0);
    chk("rst:ray_origin", 64'(ray_origin), 64'd0);
    chk("rst:ray_dir", 64'(ray_dir), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst:cam_ready", 64'(cam_ready), 64'd1);
    chk("rst:busy", 64'(busy), 64'd0);

    // Miss on first query
    fill_rand();
    resp_hit[0] = 1'b0;
    do_pixel(rnd_vec(500), rnd_vec(256), 3, 1'b0, "miss");

    // Black emitter stops on zero throughput after one ray
    fill_rand();
    resp_hit[0] = 1'b1;
    resp_mat[0].emit  = 24'h808080;
    resp_mat[0].color = 24'h000000;
    do_pixel(rnd_vec(500), rnd_vec(256), 2, 1'b0, "emitter");

    // Mirror chain hits the bounce limit
    for (int i = 0; i < 8; i++) begin
      resp_hit[i] = 1'b1;
      resp_mat[i].color = 24'hFFFFFF;
      resp_mat[i].emit  = 24'h000000;
      resp_pos[i] = rnd_vec(1000);
      resp_n[i]   = '{x: fp_t'(0), y: fp_t'(0), z: fp_t'(-256)};
    end
    do_pixel(z3, '{x: fp_t'(0), y: fp_t'(0), z: fp_t'(256)}, 1, 1'b0, "mirror");

    // Saturating accumulation
    resp_mat[0].emit = 24'hFFFFFF;
    resp_mat[1].emit = 24'hFFFFFF;
    do_pixel(rnd_vec(500), rnd_vec(256), 2, 1'b0, "saturate");

    // cam_valid held while a ray is outstanding
    fill_rand();
    resp_hit[0] = 1'b1;
    resp_mat[0].color = 24'hFFFFFF;
    do_pixel(rnd_vec(500), rnd_vec(256), 4, 1'b1, "hold_cam");

    // Spurious hit_valid in IDLE
    @(negedge clk);
    hit_valid = 1'b1;
    hit_any   = 1'b0;
    @(negedge clk);
    hit_valid = 1'b0;
    chk("spurious:busy", 64'(busy), 64'd0);
    chk("spurious:pix_valid", 64'(pix_valid), 64'd0);
    chk("spurious:pix_color", 64'(pix_color), 64'(last_pix));
    @(negedge clk);
    chk("spurious:ray_valid", 64'(ray_valid), 64'd0);

    // Randomised pixels
    for (int p = 0; p < 16; p++) begin
      fill_rand();
      do_pixel(rnd_vec(1500), rnd_vec(256), int'($urandom_range(1, 5)), 1'b0, "rand");
    end

    // Reset while the reflect pipeline is busy
    fill_rand();
    @(negedge clk);
    cam_origin = rnd_vec(500);
    cam_dir    = rnd_vec(256);
    cam_valid  = 1'b1;
    @(negedge clk);
    cam_valid = 1'b0;
    to = 0;
    while (ray_valid !== 1'b1 && to < 40) begin
      @(negedge clk);
      to++;
    end
    chk("rstmid:ray_issue", 64'(ray_valid), 64'd1);
    @(negedge clk);
    hit_valid = 1'b1;
    hit_any   = 1'b1;
    hit_mat   = '{color: 24'hFFFFFF, emit: 24'h404040};
    hit_pos   = rnd_vec(500);
    hit_normal = rnd_normal();
    @(negedge clk);
    hit_valid = 1'b0;
    repeat (2) @(negedge clk);
    pix0 = pix_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstmid:busy", 64'(busy), 64'd0);
    chk("rstmid:ray_valid", 64'(ray_valid), 64'd0);
    chk("rstmid:pix_valid", 64'(pix_valid), 64'd0);
    chk("rstmid:pix_color", 64'(pix_color), 64'd0);
    chk("rstmid:ray_dir", 64'(ray_dir), 64'd0);
    chk("rstmid:ray_origin", 64'(ray_origin), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (RDLY + 4) @(negedge clk);
    chk("rstmid:no_pix", 64'(pix_cnt - pix0), 64'd0);
    chk("rstmid:idle", 64'(busy), 64'd0);
    last_pix = 24'd0;

    fill_rand();
    resp_hit[0] = 1'b1;
    resp_mat[0].color = 24'hF0F0F0;
    do_pixel(rnd_vec(500), rnd_vec(256), 2, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
